// File: rtl/riscv_pkg.sv
// Shared fetch-path constants and helpers for the instruction fetch slice.
package riscv_pkg;

  localparam int unsigned      XLEN        = 32;
  localparam logic [XLEN-1:0]  RESET_PC    = '0;
  localparam int unsigned      PC_STEP     = 4;
  localparam int unsigned      FIFO_DEPTH  = 2;
  localparam logic [1:0]       IALIGN_MASK = 2'b11;

  // Non-zero low address bits under the alignment mask mean an illegal target.
  function automatic logic is_misaligned(input logic [1:0] low_bits);
    return |(low_bits & IALIGN_MASK);
  endfunction

endpackage

// File: rtl/imem_fetch_ctrl_fifo.sv
// Small fetch buffer: circular FIFO with push/pop/flush, exposing count and empty.
// When empty the read port keeps presenting the last head value seen.
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             full;
  logic             push_ok;
  logic             pop_ok;

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_C);
  assign count = count_q;
  assign rdata = empty ? hold_q : mem_q[rd_ptr_q];

  // Next-state for storage, pointers, occupancy and the held head value.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    hold_d   = empty ? hold_q : mem_q[rd_ptr_q];
    pop_ok   = pop && !empty;
    push_ok  = push && (!full || pop_ok);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      hold_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      hold_q   <= hold_d;
    end
  end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: owns the PC, addresses instruction memory, buffers {pc, instr}
// toward decode, and handles redirect, halt and misaligned-target error.
module imem_fetch_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned     XLEN       = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC   = riscv_pkg::RESET_PC,
  parameter int unsigned     PC_STEP    = riscv_pkg::PC_STEP,
  parameter int unsigned     FIFO_DEPTH = riscv_pkg::FIFO_DEPTH
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] out_imem_address,
  input  logic [XLEN-1:0] in_imem_instruction,
  input  logic            in_redirect_valid,
  input  logic [XLEN-1:0] in_redirect_pc,
  input  logic            in_halt,
  output logic            out_valid,
  input  logic            in_ready,
  output logic [XLEN-1:0] out_instruction,
  output logic [XLEN-1:0] out_pc,
  output logic            out_fetch_err,
  output logic [31:0]     out_retired_count
);

  localparam int unsigned     CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]   DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [XLEN-1:0] STEP_C  = XLEN'(PC_STEP);

  logic [XLEN-1:0]   pc_q, pc_d;
  logic              err_q, err_d;
  logic [31:0]       ret_q, ret_d;
  logic              pop;
  logic              fetch_en;
  logic              redirect_take;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [2*XLEN-1:0] fifo_rdata;

  assign out_imem_address  = pc_q;
  assign out_valid         = !fifo_empty;
  assign out_pc            = fifo_rdata[2*XLEN-1:XLEN];
  assign out_instruction   = fifo_rdata[XLEN-1:0];
  assign out_fetch_err     = err_q;
  assign out_retired_count = ret_q;

  // Fetch enable, redirect handling, PC advance, error flag and retire counter.
  always_comb begin
    pop           = out_valid && in_ready;
    redirect_take = in_redirect_valid && !err_q;
    fetch_en      = !in_halt && !err_q && !in_redirect_valid
                    && ((fifo_count < DEPTH_C) || pop);
    pc_d          = pc_q;
    err_d         = err_q;
    ret_d         = ret_q + {31'b0, pop};
    if (redirect_take) begin
      if (is_misaligned(in_redirect_pc[1:0])) begin
        err_d = 1'b1;
      end else begin
        pc_d = in_redirect_pc;
      end
    end else if (fetch_en) begin
      pc_d = pc_q + STEP_C;
    end
  end

  // Controller registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RESET_PC;
      err_q <= 1'b0;
      ret_q <= '0;
    end else begin
      pc_q  <= pc_d;
      err_q <= err_d;
      ret_q <= ret_d;
    end
  end

  fetch_fifo #(
    .WIDTH (2*XLEN),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fetch_en),
    .pop   (pop),
    .flush (redirect_take),
    .wdata ({pc_q, in_imem_instruction}),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .empty (fifo_empty)
  );

endmodule
